fft_frame_loader: RTL and testbench
===================================

# fft_frame_loader

Streaming-to-parallel front end for the combinational recursive `FFT` core. It accepts one complex fixed-point sample per handshake and assembles `N` consecutive samples into a frame. It then presents the whole frame on a parallel bus shaped exactly like the FFT input `x[N][1:0]`, holding it under a valid/ready handshake. A one-frame collect buffer plus a one-frame output register let input streaming continue while the downstream FFT and its consumer hold the current frame.

## Interface
- `N`, default 4: samples per frame; power of two, ≥ 2.
- `W`, default 32 (`BIT_INT+BIT_FRAC`): sample component width is W+1 bits, signed, Q16.16 plus guard bit.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset: asynchronous, active-high; one clock domain.
- `s_valid`  in  1  input sample valid.
- `s_ready`  out  1  loader can accept a sample.
- `s_re`  in  W+1 signed  sample real part.
- `s_im`  in  W+1 signed  sample imaginary part.
- `s_last`  in  1  marks the final sample of a frame.
- `x`  out  [N][1:0] × W+1 signed  frame to FFT: `x[k][0]`=real, `x[k][1]`=imag, k = arrival order.
- `frame_valid`  out  1  `x` holds a complete frame.
- `frame_ready`  in  1  downstream consumes the frame.
- `frame_err`  out  1  one-cycle pulse on a framing error.

## Operation
- State: collect buffer `cbuf[N]`, write index `wr_idx` (log2 N bits), flag `cfull`, output register `obuf[N]` driving `x`, flag `frame_valid`.
- `s_ready = !cfull && !rst`.
- Accept when `s_valid && s_ready`:
  - Write the sample to `cbuf[wr_idx]`.
  - If `wr_idx == N-1`: set `cfull`, set `wr_idx` to 0.
  - Otherwise: increment `wr_idx`.
- Early `s_last`: if `s_last` is set on an accepted sample with `wr_idx < N-1`, the partial frame is discarded. `wr_idx` goes to 0, `cfull` stays 0, and `frame_err` pulses next cycle.
- Missing `s_last`: if the sample at `wr_idx == N-1` has `s_last = 0`, the frame completes normally and `frame_err` also pulses. The next accepted sample starts a new frame.
- Transfer: when `cfull && (!frame_valid || frame_ready)`, copy `obuf <= cbuf`, set `frame_valid <= 1`, clear `cfull <= 0`.
- Consume without refill: when `frame_valid && frame_ready && !cfull`, set `frame_valid <= 0`. `obuf` keeps its last value.
- If consume and transfer occur in the same cycle, transfer wins and `frame_valid` stays 1.
- No arithmetic is performed. Samples pass bit-exact, and sign and width are preserved.
- `x` is stable whenever `frame_valid=1 && frame_ready=0`.

## Timing
- Reset values: `s_ready`=0 while `rst`=1 and 1 on the first cycle after; `frame_valid`=0; `frame_err`=0; all `x`=0. `wr_idx`, `cfull` and `cbuf` are cleared.
- Reset mid-operation discards every partial and held frame immediately, because reset is asynchronous.
- Latency: the last sample is accepted at edge t. `cfull` is set after t, the transfer happens at t+1, and `frame_valid`=1 after t+1.
- Throughput with `frame_ready` held at 1: `s_ready` drops for exactly one cycle per frame, giving N samples per N+1 cycles.
- Backpressure: with `frame_ready`=0 the loader absorbs exactly 2N samples after an empty start, then `s_ready`=0 until a consume.
- `frame_err` is registered: high for the one cycle after the offending edge, and never high two cycles running for a single error.

## Test plan
- Reset, then stream re=k·65536 and im=−k for k=0..3, with `s_last` on k=3 and `frame_ready`=1 → `frame_valid` is high one cycle after the 4th acceptance, with `x[k][0]`=k·65536, `x[k][1]`=−k; `s_ready`=0 for one cycle; `frame_err`=0.
- Hold `frame_ready`=0 and stream 8 samples 1..8 → frame {1..4} held; `s_ready`=0 after the 8th. Pulse `frame_ready` for one cycle → `x`={5..8} on the next cycle, `frame_valid` stays 1, and `s_ready` returns to 1.
- Send `s_last` on the 2nd sample → `frame_err` pulses for 1 cycle and no `frame_valid`. Then send 4 clean samples 10..13 → frame {10..13}.
- Send 4 samples with no `s_last` → frame delivered and `frame_err` pulses for 1 cycle.
- Accept 2 samples, then assert `rst` mid-cycle → `s_ready`=0 and `frame_valid`=0 immediately. After release, samples 20..23 form a frame starting at index 0.
- Drive `s_valid` randomly gapped (about 50% duty) over 16 frames and compare against a reference queue → every frame is in order and bit-exact, and `x` is stable while stalled.

Source files
------------

// File: rtl/fft_frame_loader.sv
// rtl/fft_frame_loader.sv - streaming sample collector presenting complete frames to a parallel FFT input
module fft_frame_loader #(
    parameter int N = 4,
    parameter int W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic signed [W:0]   s_re,
    input  logic signed [W:0]   s_im,
    input  logic                s_last,
    output logic signed [W:0]   x [N][2],
    output logic                frame_valid,
    input  logic                frame_ready,
    output logic                frame_err
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    logic [IW-1:0]      wr_idx;
    logic               cfull;
    logic signed [W:0]  cbuf [N][2];
    logic signed [W:0]  obuf [N][2];
    logic               accept;
    logic               transfer;

    // Gating with rst keeps the source stalled for the whole reset window.
    assign s_ready  = !cfull && !rst;
    assign accept   = s_valid && s_ready;
    assign transfer = cfull && (!frame_valid || frame_ready);
    assign x        = obuf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_idx      <= '0;
            cfull       <= 1'b0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            for (int k = 0; k < N; k++) begin
                for (int c = 0; c < 2; c++) begin
                    cbuf[k][c] <= '0;
                    obuf[k][c] <= '0;
                end
            end
        end else begin
            frame_err <= 1'b0;
            if (accept) begin
                cbuf[wr_idx][0] <= s_re;
                cbuf[wr_idx][1] <= s_im;
                if (wr_idx == LAST_IDX) begin
                    cfull     <= 1'b1;
                    wr_idx    <= '0;
                    frame_err <= !s_last;
                end else if (s_last) begin
                    // Short frame: drop what was collected and restart at slot 0.
                    wr_idx    <= '0;
                    frame_err <= 1'b1;
                end else begin
                    wr_idx <= wr_idx + 1'b1;
                end
            end
            // accept and transfer are mutually exclusive, so cfull has one writer per cycle.
            if (transfer) begin
                for (int k = 0; k < N; k++) begin
                    for (int c = 0; c < 2; c++) begin
                        obuf[k][c] <= cbuf[k][c];
                    end
                end
                frame_valid <= 1'b1;
                cfull       <= 1'b0;
            end else if (frame_valid && frame_ready) begin
                frame_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fft_frame_loader.sv
// tb/tb_fft_frame_loader.sv - scoreboard bench for fft_frame_loader
module tb_fft_frame_loader;
    localparam int N = 4;
    localparam int W = 32;

    typedef logic [N-1:0][1:0][W:0] frame_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic signed [W:0] s_re = '0;
    logic signed [W:0] s_im = '0;
    logic              s_last = 1'b0;
    logic signed [W:0] x [N][2];
    logic              frame_valid;
    logic              frame_ready = 1'b0;
    logic              frame_err;

    int checks = 0;
    int errors = 0;
    int err_seen = 0;
    int exp_err = 0;
    int midx = 0;
    frame_t part;
    frame_t held;
    frame_t sb [$];
    logic stall_prev = 1'b0;
    logic rand_phase = 1'b0;

    fft_frame_loader #(.N(N), .W(W)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_re(s_re), .s_im(s_im), .s_last(s_last),
        .x(x), .frame_valid(frame_valid), .frame_ready(frame_ready),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_accept(input logic signed [W:0] re, input logic signed [W:0] im, input logic last);
        part[midx][0] = re;
        part[midx][1] = im;
        if (midx == N - 1) begin
            sb.push_back(part);
            if (!last) exp_err++;
            midx = 0;
        end else if (last) begin
            exp_err++;
            midx = 0;
        end else begin
            midx++;
        end
    endtask

    // Returns just after the accepting edge with s_valid dropped.
    task automatic send(input logic signed [W:0] re, input logic signed [W:0] im, input logic last);
        logic ok;
        bit done;
        done = 0;
        s_valid = 1'b1;
        s_re = re;
        s_im = im;
        s_last = last;
        for (int i = 0; i < 1000 && !done; i++) begin
            @(negedge clk);
            ok = s_ready;
            @(posedge clk);
            if (ok) done = 1;
        end
        if (!done) check("send_timeout", 0, 1);
        else model_accept(re, im, last);
        #1;
        s_valid = 1'b0;
        s_last = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err) err_seen++;
            if (stall_prev) begin
                check("stall_valid", frame_valid, 1);
                for (int k = 0; k < N; k++)
                    for (int c = 0; c < 2; c++)
                        check("stall_x", x[k][c], $signed(held[k][c]));
            end
            if (frame_valid && frame_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_frame", 1, 0);
                end else begin
                    frame_t f;
                    f = sb.pop_front();
                    for (int k = 0; k < N; k++)
                        for (int c = 0; c < 2; c++)
                            check("frame_x", x[k][c], $signed(f[k][c]));
                end
            end
            stall_prev = frame_valid && !frame_ready;
            for (int k = 0; k < N; k++)
                for (int c = 0; c < 2; c++)
                    held[k][c] = x[k][c];
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ready", s_ready, 0);
        check("rst_frame_valid", frame_valid, 0);
        check("rst_frame_err", frame_err, 0);
        for (int k = 0; k < N; k++)
            for (int c = 0; c < 2; c++)
                check("rst_x", x[k][c], 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_s_ready", s_ready, 1);
        @(posedge clk);
        #1;

        // Basic frame with latency
        frame_ready = 1'b1;
        for (int k = 0; k < N; k++) send(33'(k * 65536), -33'(k), k == N - 1);
        @(negedge clk);
        check("lat_fv_t", frame_valid, 0);
        check("lat_s_ready_low", s_ready, 0);
        @(negedge clk);
        check("lat_fv_t1", frame_valid, 1);
        check("lat_s_ready_back", s_ready, 1);
        check("lat_frame_err", frame_err, 0);
        repeat (2) @(posedge clk);
        #1;

        // Backpressure: 2N samples absorbed
        frame_ready = 1'b0;
        for (int k = 1; k <= 2 * N; k++) send(33'(k), -33'(k), (k % N) == 0);
        @(negedge clk);
        check("bp_s_ready", s_ready, 0);
        check("bp_fv", frame_valid, 1);
        check("bp_x0", x[0][0], 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("bp_s_ready_hold", s_ready, 0);
        @(posedge clk);
        #1;
        frame_ready = 1'b1;
        @(posedge clk);
        #1;
        frame_ready = 1'b0;
        @(negedge clk);
        check("bp_refill_fv", frame_valid, 1);
        check("bp_refill_x0", x[0][0], 5);
        check("bp_refill_x3", x[3][1], -8);
        check("bp_refill_s_ready", s_ready, 1);
        @(posedge clk);
        #1;
        frame_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Early s_last
        send(30, 0, 1'b0);
        send(31, 0, 1'b1);
        @(negedge clk);
        check("early_err", frame_err, 1);
        @(negedge clk);
        check("early_err_once", frame_err, 0);
        check("early_no_fv", frame_valid, 0);
        @(posedge clk);
        #1;
        for (int k = 10; k <= 13; k++) send(33'(k), 33'(k + 100), k == 13);
        repeat (3) @(posedge clk);
        #1;

        // Missing s_last
        for (int k = 40; k <= 43; k++) send(33'(k), 33'(-k), 1'b0);
        @(negedge clk);
        check("miss_err", frame_err, 1);
        @(negedge clk);
        check("miss_err_once", frame_err, 0);
        check("miss_fv", frame_valid, 1);
        repeat (2) @(posedge clk);
        #1;

        // Asynchronous reset mid-frame
        send(50, 0, 1'b0);
        send(51, 0, 1'b0);
        #3;
        rst = 1'b1;
        midx = 0;
        sb.delete();
        #1;
        check("arst_s_ready", s_ready, 0);
        check("arst_fv", frame_valid, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 20; k <= 23; k++) send(33'(k), 33'(k), k == 23);
        repeat (3) @(posedge clk);
        #1;

        // Randomly gapped stream with random downstream stalls
        rand_phase = 1'b1;
        fork
            begin
                for (int f = 0; f < 16; f++) begin
                    for (int k = 0; k < N; k++) begin
                        repeat ($urandom_range(0, 1)) @(posedge clk);
                        #0;
                        send(33'($urandom), 33'($urandom), k == N - 1);
                    end
                end
                rand_phase = 1'b0;
            end
            begin
                while (rand_phase) begin
                    @(posedge clk);
                    #1;
                    frame_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        frame_ready = 1'b1;
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("drain_empty", sb.size(), 0);
        check("err_count", err_seen, exp_err);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
